// File: rtl/guvm_data_mem_responder_if.sv
// Core data-side request/grant/rvalid bus between the core (master) and the
// data-memory responder (slave).
interface guvm_data_mem_responder_if;
  logic        data_req_i;
  logic        data_gnt_o;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;

  modport master (
    output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );

  modport slave (
    input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );
endinterface

// File: rtl/guvm_data_mem_responder.sv
// Data-memory responder: grants core data requests after a programmable
// delay, services word reads / byte-enabled writes from an internal array,
// answers with a fixed one-cycle rvalid and publishes committed stores.
module guvm_data_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned GNT_DELAY   = 0,
  parameter logic [31:0] ERR_RDATA   = 32'hDEADBEEF
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            stall_i,
  guvm_data_mem_responder_if.slave        bus,
  output logic                            obs_valid_o,
  output logic [31:0]                     obs_addr_o,
  output logic [31:0]                     obs_wdata_o,
  output logic [3:0]                      obs_be_o
);

  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  DLY        = 4'(GNT_DELAY);
  localparam bit          HAS_DELAY  = (GNT_DELAY != 0);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_e;

  state_e            state_r, state_nxt_s;
  logic [3:0]        cnt_r, cnt_nxt_s;
  logic              gnt_s;
  logic              accept_s;
  logic [31:0]       off_s;
  logic              in_range_s;
  logic [IDX_W-1:0]  idx_s;
  logic [31:0]       mem_r [DEPTH_WORDS];

  // Address decode: offset from the window base, range test, word index.
  always_comb begin
    off_s      = bus.data_addr_i - BASE_ADDR;
    in_range_s = ({1'b0, off_s} < SPAN_BYTES);
    idx_s      = off_s[IDX_W+1:2];
  end

  // Grant FSM next state / grant; with no delay the grant is a pure gate of req.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    gnt_s       = 1'b0;
    if (!HAS_DELAY) begin
      gnt_s       = bus.data_req_i && !stall_i && rst_ni;
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.data_req_i) begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = 4'd1;
          end else begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 4'd0;
          end
        end
        ST_WAIT: begin
          gnt_s = bus.data_req_i && (cnt_r == DLY) && !stall_i && rst_ni;
          // Accept or a withdrawn request both restart the wait from scratch.
          if (!bus.data_req_i || gnt_s) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 4'd0;
          end else if (cnt_r == DLY) begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = cnt_r;
          end else begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = cnt_r + 4'd1;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 4'd0;
        end
      endcase
    end
  end

  assign bus.data_gnt_o = gnt_s;
  assign accept_s       = bus.data_req_i && gnt_s;

  // Grant FSM state and wait counter.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Memory array: in-range writes commit enabled bytes at the accept edge.
  always_ff @(posedge clk_i) begin
    if (accept_s && bus.data_we_i && in_range_s) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.data_be_i[k]) begin
          mem_r[idx_s][8*k +: 8] <= bus.data_wdata_i[8*k +: 8];
        end
      end
    end
  end

  // Registered response and store-observation outputs, one cycle after accept.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bus.data_rvalid_o <= 1'b0;
      bus.data_rdata_o  <= 32'd0;
      bus.data_err_o    <= 1'b0;
      obs_valid_o       <= 1'b0;
      obs_addr_o        <= 32'd0;
      obs_wdata_o       <= 32'd0;
      obs_be_o          <= 4'd0;
    end else begin
      bus.data_rvalid_o <= accept_s;
      bus.data_err_o    <= accept_s && !in_range_s;
      if (accept_s && !bus.data_we_i) begin
        bus.data_rdata_o <= in_range_s ? mem_r[idx_s] : ERR_RDATA;
      end else begin
        bus.data_rdata_o <= 32'd0;
      end
      obs_valid_o <= accept_s && bus.data_we_i && in_range_s;
      if (accept_s && bus.data_we_i && in_range_s) begin
        obs_addr_o  <= {bus.data_addr_i[31:2], 2'b00};
        obs_wdata_o <= bus.data_wdata_i;
        obs_be_o    <= bus.data_be_i;
      end else begin
        obs_addr_o  <= obs_addr_o;
        obs_wdata_o <= obs_wdata_o;
        obs_be_o    <= obs_be_o;
      end
    end
  end

endmodule
